aead_serial_loader: RTL and testbench
=====================================

# aead_serial_loader

Bit-serial input front end for the AEAD core. Shifts key, nonce, associated data and plaintext in MSB-first, one bit per field per enabled cycle, and presents them as parallel registers. Arbitrates encryption/decryption start requests into single-cycle start pulses to the core, then holds the operands stable until the core reports completion. Sits between the serial pins that the testbench drives and the parallel operand inputs of the AEAD datapath.

## Interface

Reset is asynchronous and active-low, on port `rst`. There is one clock, `clk`.

Parameters:
- `k`, default 128: key width in bits.
- `l`, default 40: associated-data width in bits.
- `y`, default 40: plaintext width in bits.
- Derived, not overridable: `n` = 128 (nonce width); `m` = max(`k`, `n`, `l`, `y`) (frame length in bits).

Ports:
- `clk`, in, 1: clock. All state updates on the rising edge.
- `rst`, in, 1: asynchronous active-low reset.
- `load_enxSI`, in, 1: the four serial bits are valid this cycle.
- `keyxSI`, `noncexSI`, `associated_dataxSI`, `plain_textxSI`, in, 1 each: serial data, MSB first.
- `encryption_startxSI`, in, 1: encryption request (level, sampled).
- `decryption_startxSI`, in, 1: decryption request (level, sampled).
- `core_donexSI`, in, 1: the core finished the current operation.
- `key`, out, `k`: assembled key.
- `nonce`, out, 128: assembled nonce.
- `associated_data`, out, `l`: assembled AD.
- `plain_text`, out, `y`: assembled plaintext.
- `loaded`, out, 1: a full frame is held.
- `enc_start`, out, 1: one-cycle start pulse to the core.
- `dec_start`, out, 1: one-cycle start pulse to the core.
- `busy`, out, 1: the core operation is in flight.

## Operation

- Bit counter `ctr` is ceil(log2(`m`+1)) bits wide.
- States and transitions:
  - IDLE: on `load_enxSI`=1, capture bit 0 and go to LOAD.
  - LOAD: each cycle with `load_enxSI`=1 captures bit `ctr` and increments `ctr`. Capturing bit `m`-1 goes to READY. `load_enxSI`=0 pauses: `ctr` and data hold, with no timeout.
  - READY: `loaded`=1.
    - `encryption_startxSI`=1 → `enc_start` pulse, go to RUN.
    - Otherwise `decryption_startxSI`=1 → `dec_start` pulse, go to RUN. Encryption wins if both requests are high.
    - Otherwise `load_enxSI`=1 → clear `ctr`, capture bit 0 of a new frame, go to LOAD, `loaded`=0.
    - A start request outranks `load_enxSI` in the same cycle.
  - RUN: `busy`=1. All operand registers are frozen, and `load_enxSI` and both start inputs are ignored. `core_donexSI`=1 returns to READY with operands retained, so decryption can follow encryption on the same frame.
- Capture rule, applied to each field F of width w: bit index i = `ctr` is written to F[w-1-i] only when i < w. Bits presented at i ≥ w are discarded. Fields shorter than `m` therefore take their bits from the first w cycles.
- Start inputs are level-sensitive. After RUN→READY, a request still held high starts a new operation immediately. Upstream deasserts its request before `core_donexSI`.
- A start request while in IDLE or LOAD is ignored; it is not queued.
- Reset, asynchronous at any time (including mid-load or mid-RUN): state IDLE, `ctr`=0, `key`/`nonce`/`associated_data`/`plain_text`=0, and `loaded`, `enc_start`, `dec_start`, `busy` all 0.

## Timing

- All outputs are registered.
- The bit sampled at edge E is visible on the parallel outputs after E.
- `loaded` rises on the edge that samples bit `m`-1, so it is high from the following cycle.
- Load latency is exactly `m` enabled cycles. Gaps add their own cycle count.
- Start request sampled at edge E in READY:
  - the matching start pulse is high for exactly one cycle, E to E+1;
  - `busy` rises at E and falls on the edge that samples `core_donexSI`.
- `core_donexSI` is sampled only in RUN. If it arrives in the same cycle as the start pulse, the block still returns to READY on the next sampled edge where it is high.
- Back-to-back: the earliest next start pulse is 1 cycle after the return to READY.

## Test plan

- **Frame load.** `k`=128, `l`=`y`=40. Stream key 000102…0f, nonce 101112…1f, AD 4153434f4e, PT 6173636f6e over 128 cycles → the parallel outputs equal those values exactly, and `loaded` rises the cycle after bit 127. Drive bits 40–127 of AD/PT as 1 → AD and PT are unchanged.
- **Gapped load.** Same frame with `load_enxSI` low for 7 random gaps → identical result; `loaded` is delayed by exactly the total gap cycles.
- **Start arbitration.** In READY, raise `encryption_startxSI` and `decryption_startxSI` together → only `enc_start` pulses for one cycle, and `busy`=1. A stray start while loading → no pulse.
- **Run freeze and re-run.** During RUN, toggle the serial inputs with `load_enxSI`=1 → operands unchanged. Assert `core_donexSI` → READY. Then `decryption_startxSI` → `dec_start` pulse with the same operands.
- **Reset mid-load.** Drop `rst` after bit 60 → all outputs 0 immediately, without waiting for a clock edge. After release, a full reload yields the correct frame.
- **Reload from READY.** `load_enxSI` in READY without any start request → `loaded` falls, `ctr` restarts, and a new frame overwrites the old one with no residue from the previous frame.

Source files
------------

// File: rtl/aead_serial_loader_if.sv
// Signal bundle between the serial pin driver and the AEAD serial loader.
// The master drives the serial pins and requests; the slave presents the parallel operands.
interface aead_serial_loader_if #(
  parameter int k = 128,
  parameter int l = 40,
  parameter int y = 40
);
  logic           load_enxSI;
  logic           keyxSI;
  logic           noncexSI;
  logic           associated_dataxSI;
  logic           plain_textxSI;
  logic           encryption_startxSI;
  logic           decryption_startxSI;
  logic           core_donexSI;
  logic [k-1:0]   key;
  logic [127:0]   nonce;
  logic [l-1:0]   associated_data;
  logic [y-1:0]   plain_text;
  logic           loaded;
  logic           enc_start;
  logic           dec_start;
  logic           busy;

  modport master (
    output load_enxSI, keyxSI, noncexSI, associated_dataxSI, plain_textxSI,
           encryption_startxSI, decryption_startxSI, core_donexSI,
    input  key, nonce, associated_data, plain_text, loaded, enc_start, dec_start, busy
  );

  modport slave (
    input  load_enxSI, keyxSI, noncexSI, associated_dataxSI, plain_textxSI,
           encryption_startxSI, decryption_startxSI, core_donexSI,
    output key, nonce, associated_data, plain_text, loaded, enc_start, dec_start, busy
  );
endinterface

// File: rtl/aead_serial_loader.sv
// Bit-serial operand loader for the AEAD core: assembles key/nonce/AD/PT MSB-first,
// then turns level start requests into single-cycle start pulses and holds operands while busy.
module aead_serial_loader #(
  parameter int k = 128,
  parameter int l = 40,
  parameter int y = 40
) (
  input  logic                clk,
  input  logic                rst,
  aead_serial_loader_if.slave bus
);
   localparam int n    = 128;
   localparam int m_kn = (k > n) ? k : n;
   localparam int m_ly = (l > y) ? l : y;
   localparam int m    = (m_kn > m_ly) ? m_kn : m_ly;
   localparam int cw   = $clog2(m + 1);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_LOAD  = 2'd1;
   localparam logic [1:0] ST_READY = 2'd2;
   localparam logic [1:0] ST_RUN   = 2'd3;

   logic [1:0]    state;
   logic [cw-1:0] ctr;
   logic [cw-1:0] idx;
   logic          cap;
   logic [k-1:0]  key_q, key_d;
   logic [n-1:0]  nonce_q, nonce_d;
   logic [l-1:0]  ad_q, ad_d;
   logic [y-1:0]  pt_q, pt_d;
   logic          loaded_q, enc_q, dec_q, busy_q;

   // Capture enable and bit index; a start request in READY outranks a new frame.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path infers a latch.
      cap = 1'b0;
      idx = ctr;
      case (state)
         ST_IDLE:  begin cap = bus.load_enxSI; idx = '0; end
         ST_LOAD:  cap = bus.load_enxSI;
         ST_READY: begin
            cap = bus.load_enxSI & ~bus.encryption_startxSI & ~bus.decryption_startxSI;
            idx = '0;
         end
         default:  cap = 1'b0;
      endcase

      key_d   = key_q;
      nonce_d = nonce_q;
      ad_d    = ad_q;
      pt_d    = pt_q;
      // Bit i lands at position w-1-i; indices beyond a field's width match nothing.
      for (int b = 0; b < k; b++) if (cap && idx == cw'(k - 1 - b)) key_d[b]   = bus.keyxSI;
      for (int b = 0; b < n; b++) if (cap && idx == cw'(n - 1 - b)) nonce_d[b] = bus.noncexSI;
      for (int b = 0; b < l; b++) if (cap && idx == cw'(l - 1 - b)) ad_d[b]    = bus.associated_dataxSI;
      for (int b = 0; b < y; b++) if (cap && idx == cw'(y - 1 - b)) pt_d[b]    = bus.plain_textxSI;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= ST_IDLE;
         ctr      <= '0;
         key_q    <= '0;
         nonce_q  <= '0;
         ad_q     <= '0;
         pt_q     <= '0;
         loaded_q <= 1'b0;
         enc_q    <= 1'b0;
         dec_q    <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
         key_q   <= key_d;
         nonce_q <= nonce_d;
         ad_q    <= ad_d;
         pt_q    <= pt_d;
         enc_q   <= 1'b0;
         dec_q   <= 1'b0;
         case (state)
            ST_IDLE: if (bus.load_enxSI) begin
               ctr   <= cw'(1);
               state <= ST_LOAD;
            end
            ST_LOAD: if (bus.load_enxSI) begin
               if (ctr == cw'(m - 1)) begin
                  ctr      <= '0;
                  loaded_q <= 1'b1;
                  state    <= ST_READY;
               end else begin
                  ctr <= ctr + cw'(1);
               end
            end
            ST_READY: begin
               if (bus.encryption_startxSI) begin
                  enc_q  <= 1'b1;
                  busy_q <= 1'b1;
                  state  <= ST_RUN;
               end else if (bus.decryption_startxSI) begin
                  dec_q  <= 1'b1;
                  busy_q <= 1'b1;
                  state  <= ST_RUN;
               end else if (bus.load_enxSI) begin
                  ctr      <= cw'(1);
                  loaded_q <= 1'b0;
                  state    <= ST_LOAD;
               end
            end
            ST_RUN: if (bus.core_donexSI) begin
               busy_q <= 1'b0;
               state  <= ST_READY;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign bus.key             = key_q;
   assign bus.nonce           = nonce_q;
   assign bus.associated_data = ad_q;
   assign bus.plain_text      = pt_q;
   assign bus.loaded          = loaded_q;
   assign bus.enc_start       = enc_q;
   assign bus.dec_start       = dec_q;
   assign bus.busy            = busy_q;
endmodule

// File: tb/tb_aead_serial_loader.sv
// Randomized bench for aead_serial_loader: a frame-level reference model checked every cycle,
// plus directed frame, arbitration, freeze, reset and reload scenarios with literal expectations.
module tb_aead_serial_loader;
   localparam int K = 128;
   localparam int L = 40;
   localparam int Y = 40;
   localparam int N = 128;
   localparam int M = 128;

   logic clk;
   logic rst;
   int   vectors = 0;
   int   errors  = 0;

   aead_serial_loader_if #(.k(K), .l(L), .y(Y)) bus ();
   aead_serial_loader #(.k(K), .l(L), .y(Y)) dut (.clk(clk), .rst(rst), .bus(bus));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      vectors++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: bits received so far, whether a frame is held, and whether the core runs.
   logic [127:0] mk, mn, ma, mp;
   int           got;
   logic         m_loaded, m_busy, m_enc, m_dec;

   task automatic put(inout logic [127:0] f, input int w, input int i, input logic b);
      logic [127:0] mask;
      if (i < w) begin
         mask = 128'd1 << (w - 1 - i);
         f = b ? (f | mask) : (f & ~mask);
      end
   endtask

   initial forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
         mk = '0; mn = '0; ma = '0; mp = '0;
         got = 0; m_loaded = 0; m_busy = 0; m_enc = 0; m_dec = 0;
      end else begin
         m_enc = 0;
         m_dec = 0;
         if (m_busy) begin
            if (bus.core_donexSI) m_busy = 0;
         end else if (m_loaded && (bus.encryption_startxSI || bus.decryption_startxSI)) begin
            if (bus.encryption_startxSI) m_enc = 1; else m_dec = 1;
            m_busy = 1;
         end else if (bus.load_enxSI) begin
            if (m_loaded) begin m_loaded = 0; got = 0; end
            put(mk, K, got, bus.keyxSI);
            put(mn, N, got, bus.noncexSI);
            put(ma, L, got, bus.associated_dataxSI);
            put(mp, Y, got, bus.plain_textxSI);
            got++;
            if (got == M) begin m_loaded = 1; got = 0; end
         end
      end
   end

   always @(negedge clk) begin
      check("key",       128'(bus.key), mk);
      check("nonce",     128'(bus.nonce), mn);
      check("ad",        128'(bus.associated_data), ma);
      check("pt",        128'(bus.plain_text), mp);
      check("loaded",    128'(bus.loaded), 128'(m_loaded));
      check("enc_start", 128'(bus.enc_start), 128'(m_enc));
      check("dec_start", 128'(bus.dec_start), 128'(m_dec));
      check("busy",      128'(bus.busy), 128'(m_busy));
   end

   // Stimulus helpers.
   logic [127:0] fk, fn, fa, fp;

   function automatic logic src_bit(input logic [127:0] v, input int w, input int i, input logic fill);
      logic [127:0] t;
      if (i >= w) return fill;
      t = v >> (w - 1 - i);
      return t[0];
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic rand_serial();
      bus.keyxSI             = 1'($urandom);
      bus.noncexSI           = 1'($urandom);
      bus.associated_dataxSI = 1'($urandom);
      bus.plain_textxSI      = 1'($urandom);
   endtask

   task automatic drive_bit(input int i, input logic fill);
      bus.load_enxSI         = 1'b1;
      bus.keyxSI             = src_bit(fk, K, i, fill);
      bus.noncexSI           = src_bit(fn, N, i, fill);
      bus.associated_dataxSI = src_bit(fa, L, i, fill);
      bus.plain_textxSI      = src_bit(fp, Y, i, fill);
   endtask

   task automatic load_frame(input int gaps, input logic fill, input bit stray, output int cycles);
      int gap_at[M];
      for (int i = 0; i < M; i++) gap_at[i] = 0;
      for (int g = 0; g < gaps; g++) gap_at[$urandom_range(M - 1, 1)]++;
      cycles = 0;
      for (int i = 0; i < M; i++) begin
         for (int g = 0; g < gap_at[i]; g++) begin
            bus.load_enxSI = 1'b0;
            rand_serial();
            tick();
            cycles++;
         end
         bus.encryption_startxSI = stray && i >= 10 && i < 20;
         if (stray && i == 15) check("stray_no_pulse", 128'(bus.enc_start), 128'd0);
         if (i == 1)     check("loaded_low_after_bit0", 128'(bus.loaded), 128'd0);
         if (i == M - 1) check("loaded_low_before_last", 128'(bus.loaded), 128'd0);
         drive_bit(i, fill);
         tick();
         cycles++;
      end
      bus.load_enxSI = 1'b0;
      bus.encryption_startxSI = 1'b0;
   endtask

   task automatic check_frame(input string tag);
      check({tag, "_key"},    128'(bus.key), fk);
      check({tag, "_nonce"},  128'(bus.nonce), fn);
      check({tag, "_ad"},     128'(bus.associated_data), fa);
      check({tag, "_pt"},     128'(bus.plain_text), fp);
      check({tag, "_loaded"}, 128'(bus.loaded), 128'd1);
   endtask

   task automatic rand_frame();
      fk = {$urandom, $urandom, $urandom, $urandom};
      fn = {$urandom, $urandom, $urandom, $urandom};
      fa = {88'd0, 8'($urandom), $urandom};
      fp = {88'd0, 8'($urandom), $urandom};
   endtask

   initial begin
      int cyc;
      rst = 1'b0;
      bus.load_enxSI = 0; bus.keyxSI = 0; bus.noncexSI = 0;
      bus.associated_dataxSI = 0; bus.plain_textxSI = 0;
      bus.encryption_startxSI = 0; bus.decryption_startxSI = 0; bus.core_donexSI = 0;
      @(negedge clk);
      check("rst_key", 128'(bus.key), 128'd0);
      check("rst_flags", 128'({bus.loaded, bus.enc_start, bus.dec_start, bus.busy}), 128'd0);
      tick();
      rst = 1'b1;

      // Frame load with ones driven past the end of AD/PT.
      fk = 128'h000102030405060708090a0b0c0d0e0f;
      fn = 128'h101112131415161718191a1b1c1d1e1f;
      fa = 128'h4153434f4e;
      fp = 128'h6173636f6e;
      load_frame(0, 1'b1, 0, cyc);
      check("load_cycles", 128'(cyc), 128'd128);
      check_frame("frame_a");

      // Both requests together: encryption wins.
      bus.encryption_startxSI = 1; bus.decryption_startxSI = 1;
      tick();
      check("arb_enc", 128'(bus.enc_start), 128'd1);
      check("arb_dec", 128'(bus.dec_start), 128'd0);
      check("arb_busy", 128'(bus.busy), 128'd1);
      bus.encryption_startxSI = 0; bus.decryption_startxSI = 0;

      // Serial activity and requests during RUN must not disturb anything.
      for (int i = 0; i < 12; i++) begin
         bus.load_enxSI = 1; rand_serial();
         bus.encryption_startxSI = 1'($urandom); bus.decryption_startxSI = 1'($urandom);
         tick();
      end
      bus.load_enxSI = 0; bus.encryption_startxSI = 0; bus.decryption_startxSI = 0;
      check_frame("frozen");
      check("pulse_single", 128'(bus.enc_start), 128'd0);

      bus.core_donexSI = 1; tick(); bus.core_donexSI = 0;
      check("done_busy", 128'(bus.busy), 128'd0);

      // Decryption on the same frame; done coincides with the pulse cycle.
      bus.decryption_startxSI = 1; tick();
      check("dec_pulse", 128'(bus.dec_start), 128'd1);
      check_frame("rerun");
      bus.decryption_startxSI = 0; bus.core_donexSI = 1; tick();
      bus.core_donexSI = 0;
      check("early_done", 128'(bus.busy), 128'd0);

      // Request held across completion restarts one cycle after the return to READY.
      bus.encryption_startxSI = 1; tick();
      bus.core_donexSI = 1; tick();
      bus.core_donexSI = 0;
      check("b2b_gap", 128'(bus.enc_start), 128'd0);
      tick();
      check("b2b_pulse", 128'(bus.enc_start), 128'd1);
      bus.encryption_startxSI = 0; bus.core_donexSI = 1; tick(); bus.core_donexSI = 0;

      // Gapped reload from READY of the same frame.
      load_frame(7, 1'b0, 0, cyc);
      check("gap_cycles", 128'(cyc), 128'd135);
      check_frame("gapped");

      // Reload from READY with a fresh random frame: no residue.
      rand_frame();
      load_frame(0, 1'($urandom), 0, cyc);
      check_frame("reload");

      // Asynchronous reset after bit 60, then a full reload with stray start requests.
      rand_frame();
      for (int i = 0; i <= 60; i++) begin drive_bit(i, 1'b0); tick(); end
      bus.load_enxSI = 0;
      rst = 1'b0;
      #1;
      check("async_rst_key", 128'(bus.key), 128'd0);
      check("async_rst_data", 128'(bus.nonce | 128'(bus.associated_data) | 128'(bus.plain_text)), 128'd0);
      tick();
      rst = 1'b1;
      load_frame(3, 1'b1, 1, cyc);
      check_frame("after_rst");

      // Random traffic, including occasional asynchronous resets.
      for (int c = 0; c < 4000; c++) begin
         bus.load_enxSI          = ($urandom_range(3) != 0);
         rand_serial();
         bus.encryption_startxSI = ($urandom_range(15) == 0);
         bus.decryption_startxSI = ($urandom_range(15) == 0);
         bus.core_donexSI        = ($urandom_range(7) == 0);
         if ($urandom_range(999) == 0) begin rst = 1'b0; #2; rst = 1'b1; end
         tick();
      end

      @(negedge clk);
      #1;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end
endmodule
